// File: rtl/uart_pkg.sv
// Shared UART types and constants for the user-area UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 1250;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit,
// and restarts from 0 whenever clr is asserted.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == CNT_LAST);

  // Wrapping on bit_done lets DATA move bit to bit without a state change.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: 8N1 frames LSB first, or 8E1 when UART_TX_PARITY_EN is defined.
// All outputs are registered; start requests are only looked at in IDLE.
//
// state  | meaning
// IDLE   | line high, waiting for i_tx_start
// START  | start bit (0) on the line
// DATA   | shifting out the 8 data bits, LSB first
// PARITY | even parity bit of the latched byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (1) on the line
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx,
  output logic       o_tx_busy,
  output logic       o_tx_start_clear,
  output logic       o_txd
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      txd_q, txd_d;
  logic                      busy_q, busy_d;
  logic                      clear_q, clear_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif
  logic                      bit_done;
  logic                      timer_clr;

  // Every state change restarts the bit period.
  assign timer_clr = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    clear_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (i_tx_start) begin
          shift_d = i_tx;
          idx_d   = '0;
          state_d = START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          clear_d = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_tx;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            txd_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_txd            = txd_q;
  assign o_tx_busy        = busy_q;
  assign o_tx_start_clear = clear_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: two instances (4 and 2 clocks per bit) with a line
// receiver per instance checking frames against a queue of expected bytes.
module tb_uart_tx_engine;

  localparam int C0 = 4;
  localparam int C1 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
  logic       busy0, clr0, txd0;
  logic       busy1, clr1, txd1;

  uart_tx_engine #(.CLKS_PER_BIT(C0)) dut0 (
    .clk(clk), .rst(rst), .i_tx_start(start0), .i_tx(tx0),
    .o_tx_busy(busy0), .o_tx_start_clear(clr0), .o_txd(txd0)
  );

  uart_tx_engine #(.CLKS_PER_BIT(C1)) dut1 (
    .clk(clk), .rst(rst), .i_tx_start(start1), .i_tx(tx1),
    .o_tx_busy(busy1), .o_tx_start_clear(clr1), .o_txd(txd1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  logic busy_p[2];
  int   hi_cnt[2];
  int   lo_cnt[2];
  int   last_gap[2];
  int   frames[2];
  logic samp[2][NB*C0];

  task automatic mon_step(input int id, input logic busy, input logic txd, input logic clr);
    int         c;
    int         unstable;
    logic [7:0] data;
    logic [7:0] exp_b;
    logic       have_exp;
    c = (id == 0) ? C0 : C1;
    if (rst) begin
      busy_p[id] = 1'b0;
      hi_cnt[id] = 0;
      lo_cnt[id] = 0;
      return;
    end
    if (clr || (busy && !busy_p[id]))
      check_eq($sformatf("clear_pulse%0d", id), clr, busy && !busy_p[id]);
    if (busy) begin
      if (!busy_p[id]) last_gap[id] = lo_cnt[id];
      if (hi_cnt[id] < NB*C0) samp[id][hi_cnt[id]] = txd;
      hi_cnt[id]++;
      lo_cnt[id] = 0;
    end else begin
      check_eq($sformatf("idle_txd%0d", id), txd, 1);
      if (busy_p[id]) begin
        frames[id]++;
        check_eq($sformatf("busy_len%0d", id), hi_cnt[id], NB*c);
        if (hi_cnt[id] == NB*c) begin
          unstable = 0;
          for (int i = 0; i < NB; i++)
            for (int j = 1; j < c; j++)
              if (samp[id][i*c+j] !== samp[id][i*c]) unstable++;
          check_eq($sformatf("bit_width%0d", id), unstable, 0);
          for (int i = 0; i < 8; i++) data[i] = samp[id][(i+1)*c];
          check_eq($sformatf("start_bit%0d", id), samp[id][0], 0);
          check_eq($sformatf("stop_bit%0d", id), samp[id][(NB-1)*c], 1);
          have_exp = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
          check_eq($sformatf("frame_expected%0d", id), have_exp, 1);
          if (have_exp) begin
            exp_b = (id == 0) ? q0.pop_front() : q1.pop_front();
            check_eq($sformatf("data%0d", id), data, exp_b);
`ifdef UART_TX_PARITY_EN
            check_eq($sformatf("parity%0d", id), samp[id][9*c], ^exp_b);
`endif
          end
        end
      end
      hi_cnt[id] = 0;
      lo_cnt[id]++;
    end
    busy_p[id] = busy;
  endtask

  always @(negedge clk) begin
    mon_step(0, busy0, txd0, clr0);
    mon_step(1, busy1, txd1, clr1);
  end

  task automatic start_frame(input int id, input logic [7:0] b, input bit hold);
    bit seen;
    seen = 1'b0;
    if (id == 0) begin tx0 = b; start0 = 1'b1; q0.push_back(b); end
    else         begin tx1 = b; start1 = 1'b1; q1.push_back(b); end
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if ((id == 0) ? clr0 : clr1) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq($sformatf("accept%0d", id), seen, 1);
    if (!hold) begin
      if (id == 0) start0 = 1'b0;
      else         start1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int id);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (!((id == 0) ? busy0 : busy1)) begin
        idle = 1'b1;
        break;
      end
    end
    check_eq($sformatf("idle_reached%0d", id), idle, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    frames[0] = 0;
    frames[1] = 0;
    last_gap[0] = 0;
    last_gap[1] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", txd0, 1);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_clear", clr0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic frame and a parity-1 byte
    start_frame(0, 8'hA5, 1'b0);
    wait_idle(0);
    start_frame(0, 8'h07, 1'b0);
    wait_idle(0);

    // start request during DATA must be ignored
    start_frame(0, 8'h00, 1'b0);
    repeat (C0*3) @(negedge clk);
    check_eq("busy_during_data", busy0, 1);
    tx0 = 8'hFF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0);

    // back-to-back with the request held high
    start_frame(0, 8'h5A, 1'b1);
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (!busy0) break;
    end
    tx0 = 8'h3C;
    q0.push_back(8'h3C);
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (clr0) break;
    end
    start0 = 1'b0;
    wait_idle(0);
    check_eq("b2b_gap", last_gap[0], 1);

    // reset during data bit 3
    start_frame(0, 8'h55, 1'b0);
    repeat (18) @(negedge clk);
    check_eq("pre_rst_busy", busy0, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_txd", txd0, 1);
    check_eq("rst_mid_busy", busy0, 0);
    check_eq("rst_mid_clear", clr0, 0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_frame(0, 8'h55, 1'b0);
    wait_idle(0);

    // a few random bytes
    for (int n = 0; n < 4; n++) begin
      start_frame(0, 8'($urandom_range(0, 255)), 1'b0);
      wait_idle(0);
    end

    // minimum divider
    start_frame(1, 8'h81, 1'b0);
    wait_idle(1);

    check_eq("q0_drained", q0.size(), 0);
    check_eq("q1_drained", q1.size(), 0);
    check_eq("frames0", frames[0], 10);
    check_eq("frames1", frames[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
